// File: rtl/parallax_step_scheduler_pkg.sv
// Shared definitions for the parallax scroll step scheduler: FSM encoding,
// default geometry and the per-layer speeds loaded at reset.
package parallax_step_scheduler_pkg;

  localparam int NUM_LAYERS_DEF = 4;
  localparam int FRAC_W_DEF     = 6;
  localparam int INT_W_DEF      = 2;
  localparam int LAYER_W_DEF    = 3;
  localparam int MAX_LAYERS     = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_ISSUE,
    ST_DONE
  } state_t;

  // Scenes boot stationary; software programs real speeds before the first frame.
  localparam logic [15:0] DEFAULT_SPEED [MAX_LAYERS] = '{default: 16'h0000};

endpackage

// File: rtl/parallax_step_scheduler_if.sv
// Step-request handshake between the scheduler and the shared stepping datapath.
interface parallax_step_scheduler_if #(
  parameter int LAYER_W = 3
);
  logic               step_valid;
  logic [LAYER_W-1:0] step_layer;
  logic               step_ready;

  modport master (output step_valid, output step_layer, input step_ready);
  modport slave  (input step_valid, input step_layer, output step_ready);
endinterface

// File: rtl/parallax_speed_regs.sv
// Double-buffered per-layer speed registers: software writes the shadow bank,
// the frame start copies it into the active bank read by the sequencer.
module parallax_speed_regs #(
  parameter int                            NUM_LAYERS = 4,
  parameter int                            LAYER_W    = 3,
  parameter int                            SPD_W      = 8,
  parameter logic [NUM_LAYERS*SPD_W-1:0]   RST_SPEEDS = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [LAYER_W-1:0] wr_layer,
  input  logic [SPD_W-1:0]   wr_speed,
  input  logic               copy,
  input  logic [LAYER_W-1:0] rd_layer,
  output logic [SPD_W-1:0]   rd_speed
);

  logic [SPD_W-1:0] shadow_q [NUM_LAYERS];
  logic [SPD_W-1:0] active_q [NUM_LAYERS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < NUM_LAYERS; l++) begin
        shadow_q[l] <= RST_SPEEDS[l*SPD_W +: SPD_W];
        active_q[l] <= RST_SPEEDS[l*SPD_W +: SPD_W];
      end
    end else begin
      for (int l = 0; l < NUM_LAYERS; l++) begin
        if (wr_en && (wr_layer == LAYER_W'(l)))
          shadow_q[l] <= wr_speed;
        // A write landing on the copy cycle is forwarded so it joins this frame.
        if (copy)
          active_q[l] <= (wr_en && (wr_layer == LAYER_W'(l))) ? wr_speed : shadow_q[l];
      end
    end
  end

  always_comb begin
    rd_speed = '0;
    for (int l = 0; l < NUM_LAYERS; l++)
      if (rd_layer == LAYER_W'(l))
        rd_speed = active_q[l];
  end

endmodule

// File: rtl/parallax_step_scheduler.sv
// Per-frame parallax scroll sequencer: accumulates fixed-point layer speeds
// into fractional phases and issues one step request per whole pixel moved.
module parallax_step_scheduler
  import parallax_step_scheduler_pkg::*;
#(
  parameter int NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int FRAC_W     = FRAC_W_DEF,
  parameter int INT_W      = INT_W_DEF,
  parameter int LAYER_W    = LAYER_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_tick,
  input  logic                    pause,
  input  logic                    cfg_we,
  input  logic [LAYER_W-1:0]      cfg_layer,
  input  logic [INT_W+FRAC_W-1:0] cfg_speed,
  parallax_step_scheduler_if.master step,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overrun
);

  localparam int SPD_W = INT_W + FRAC_W;
  localparam int CNT_W = INT_W + 1;

  function automatic logic [NUM_LAYERS*SPD_W-1:0] reset_speeds();
    logic [NUM_LAYERS*SPD_W-1:0] r;
    r = '0;
    for (int l = 0; l < NUM_LAYERS; l++)
      r[l*SPD_W +: SPD_W] = SPD_W'(DEFAULT_SPEED[l]);
    return r;
  endfunction

  localparam logic [NUM_LAYERS*SPD_W-1:0] RST_SPEEDS = reset_speeds();

  state_t             state_q, state_d;
  logic [LAYER_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [FRAC_W-1:0]  phase_q [NUM_LAYERS];
  logic [FRAC_W-1:0]  phase_cur;
  logic [SPD_W-1:0]   speed_cur;
  logic [SPD_W:0]     sum;
  logic [CNT_W-1:0]   n_steps;
  logic               copy, phase_we, last_layer, accept;

  parallax_speed_regs #(
    .NUM_LAYERS (NUM_LAYERS),
    .LAYER_W    (LAYER_W),
    .SPD_W      (SPD_W),
    .RST_SPEEDS (RST_SPEEDS)
  ) u_speed_regs (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (cfg_we),
    .wr_layer (cfg_layer),
    .wr_speed (cfg_speed),
    .copy     (copy),
    .rd_layer (idx_q),
    .rd_speed (speed_cur)
  );

  always_comb begin
    phase_cur = '0;
    for (int l = 0; l < NUM_LAYERS; l++)
      if (idx_q == LAYER_W'(l))
        phase_cur = phase_q[l];
  end

  // The extra sum bit keeps the integer carry, so a wrapping phase never loses a step.
  assign sum        = {1'b0, speed_cur} + (SPD_W+1)'(phase_cur);
  assign n_steps    = sum[SPD_W:FRAC_W];
  assign last_layer = (idx_q == LAYER_W'(NUM_LAYERS - 1));
  assign accept     = step.step_valid & step.step_ready;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rem_d    = rem_q;
    copy     = 1'b0;
    phase_we = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_tick && !pause) begin
          copy    = 1'b1;
          idx_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        phase_we = 1'b1;
        if (n_steps != '0) begin
          rem_d   = n_steps;
          state_d = ST_ISSUE;
        end else if (last_layer) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_ISSUE: begin
        if (accept) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) begin
            if (last_layer) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = ST_ACCUM;
            end
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      busy    <= (state_d != ST_IDLE);
      if (frame_tick && busy)
        overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < NUM_LAYERS; l++)
        phase_q[l] <= '0;
    end else begin
      for (int l = 0; l < NUM_LAYERS; l++)
        if (phase_we && (idx_q == LAYER_W'(l)))
          phase_q[l] <= sum[FRAC_W-1:0];
    end
  end

  assign step.step_valid = (state_q == ST_ISSUE);
  assign step.step_layer = idx_q;
  assign frame_done      = (state_q == ST_DONE);

endmodule
